pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised inter-stage pipeline latch for the stalling processor. It carries the control word, instruction, valid bit and halt flag across DEPTH register stages. On top of plain stall-hold it adds flush-to-bubble, bubble canonicalisation of invalid inputs, a halt lock that freezes the chain, and a saturating stall-cycle counter. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) as the common latch.

## Interface

Parameters:
- CTRL_W, 36, control word width (1..64)
- INST_W, 16, instruction width (1..32)
- DEPTH, 1, number of back-to-back register stages (1..4)
- NOP_INST, 16'h0800, instruction value loaded for bubbles/reset (INST_W bits)
- CNT_W, 8, stall counter width (1..16)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- Stall  in  1  hold all stages this cycle
- Flush  in  1  convert all stages to bubbles this cycle
- Valid_in  in  1  input slot holds a real instruction
- control_in  in  CTRL_W  control word
- Inst_in  in  INST_W  instruction
- Halt_in  in  1  halt request travelling with the instruction
- control_out  out  CTRL_W  control word of last stage
- Inst_out  out  INST_W  instruction of last stage
- Valid_out  out  1  last stage holds a real instruction
- Halt_out  out  1  halt flag of last stage
- Halted  out  1  halt lock active
- Stall_count  out  CNT_W  saturating count of stalled valid cycles

## Operation

- Each stage k holds {valid, halt, ctrl, inst}. Stage 0 loads from inputs; stage k loads from stage k-1. Outputs come from stage DEPTH-1.
- Bubble = {valid 0, halt 0, ctrl 0, inst NOP_INST}.
- Per-cycle priority: rst > Flush > (Stall or Halted) > advance.
  - rst: all stages become bubbles; Halted 0; Stall_count 0.
  - Flush: all stages become bubbles; Halted cleared. Flush overrides Stall.
  - Stall=1 or Halted=1 (no Flush): all stages hold.
  - Advance: every stage shifts by one. Stage 0 loads the inputs if Valid_in=1, otherwise a bubble. A bubble never carries nonzero ctrl, halt or a non-NOP inst.
- Halt lock: Halted sets on the edge following any cycle where Valid_out=1 and Halt_out=1 and Flush=0. While Halted=1 the chain freezes, so outputs keep showing the halting instruction. Only rst or Flush clears it.
- Stall_count: increments in each cycle with Stall=1, Valid_out=1, Flush=0 and rst=0. It saturates at 2^CNT_W-1 with no wrap. Only rst clears it; Flush does not.
- Halted=1 with Stall=0 does not count.

## Timing

- Latency: DEPTH cycles from input to outputs when there is no stall.
- Each stall cycle adds one cycle of latency for every instruction in flight.
- Outputs are registered only; there is no combinational input-to-output path.
- Reset values: control_out 0, Inst_out NOP_INST, Valid_out 0, Halt_out 0, Halted 0, Stall_count 0. These hold the cycle after rst is sampled high.
- Halted rises one cycle after a valid halt first appears at the outputs.
- Simultaneous events:
  - Stall+Flush: flush wins and nothing is counted.
  - Flush in the same cycle as a halt reaching the outputs: lock is not set.
  - rst mid-stall: all state is cleared regardless.
- Valid_in=0 during Stall is ignored; the input is not sampled.

## Test plan

- Reset/latency: DEPTH=3; assert rst 2 cycles, then feed Inst 16'h1234, ctrl 36'h0_DEAD_BEEF with valid. Outputs equal those values with Valid_out=1 exactly 3 cycles later; before that Inst_out=16'h0800, control_out=0.
- Stall hold: DEPTH=1; load 16'hAAAA, then Stall for 4 cycles while driving 16'h5555. Inst_out stays 16'hAAAA for all 4 cycles and Stall_count=4. After release, 16'h5555 appears 1 cycle later.
- Flush beats stall: chain full of valid instructions; assert Stall and Flush together. The next cycle shows all bubbles (Valid_out=0, ctrl 0, Inst_out 16'h0800) and Stall_count is unchanged.
- Invalid input canonicalisation: Valid_in=0 with ctrl all-ones, Halt_in=1. After DEPTH cycles: ctrl 0, Halt_out 0, Inst_out NOP_INST.
- Halt lock: send a valid instruction with Halt_in=1 followed by 16'h7777. Halted=1 one cycle after Halt_out=1, and outputs stay frozen with 16'h7777 never emitted. A later Flush gives Halted=0 and bubbles.
- Counter saturation: CNT_W=4; hold Stall with valid output for 20 cycles. Stall_count reaches 15 and stays there; rst returns it to 0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline latch: DEPTH stages of {valid, halt, ctrl, inst}
// with flush-to-bubble, halt lock and a saturating stall counter.
module pipe_stage_reg #(
  parameter int CTRL_W = 36,
  parameter int INST_W = 16,
  parameter int DEPTH  = 1,
  parameter logic [INST_W-1:0] NOP_INST = 16'h0800,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              Valid_in,
  input  logic [CTRL_W-1:0] control_in,
  input  logic [INST_W-1:0] Inst_in,
  input  logic              Halt_in,
  output logic [CTRL_W-1:0] control_out,
  output logic [INST_W-1:0] Inst_out,
  output logic              Valid_out,
  output logic              Halt_out,
  output logic              Halted,
  output logic [CNT_W-1:0]  Stall_count
);

  logic              r_valid [DEPTH];
  logic              r_halt  [DEPTH];
  logic [CTRL_W-1:0] r_ctrl  [DEPTH];
  logic [INST_W-1:0] r_inst  [DEPTH];
  logic              r_halted;
  logic [CNT_W-1:0]  r_cnt;

  logic w_out_halt;
  logic w_hold;
  logic w_cnt_en;

  assign w_out_halt = r_valid[DEPTH-1] & r_halt[DEPTH-1];
  // Freeze as soon as a valid halt is visible so the halting
  // instruction stays on the outputs; Halted follows one edge later.
  assign w_hold   = Stall | r_halted | w_out_halt;
  assign w_cnt_en = Stall & r_valid[DEPTH-1] & ~Flush
                  & (r_cnt != {CNT_W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst || Flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_valid[k] <= 1'b0;
        r_halt[k]  <= 1'b0;
        r_ctrl[k]  <= '0;
        r_inst[k]  <= NOP_INST;
      end
    end else if (!w_hold) begin
      r_valid[0] <= Valid_in;
      r_halt[0]  <= Valid_in & Halt_in;
      r_ctrl[0]  <= Valid_in ? control_in : '0;
      r_inst[0]  <= Valid_in ? Inst_in : NOP_INST;
      for (int k = 1; k < DEPTH; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_halt[k]  <= r_halt[k-1];
        r_ctrl[k]  <= r_ctrl[k-1];
        r_inst[k]  <= r_inst[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || Flush) begin
      r_halted <= 1'b0;
    end else if (w_out_halt) begin
      r_halted <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_cnt_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign control_out = r_ctrl[DEPTH-1];
  assign Inst_out    = r_inst[DEPTH-1];
  assign Valid_out   = r_valid[DEPTH-1];
  assign Halt_out    = r_halt[DEPTH-1];
  assign Halted      = r_halted;
  assign Stall_count = r_cnt;

endmodule
